// File: rtl/i2s_buf_pkg.sv
// Shared widths, constants and sign-extension helper for the I2S ping-pong block buffer.
package i2s_buf_pkg;

  localparam int unsigned DEFAULT_SAMPLE_W = 24;
  localparam int unsigned DEFAULT_OUT_W    = 32;
  localparam int unsigned WORD_SIZE        = 32;
  localparam int unsigned BLK_SEQ_W        = 8;
  localparam int unsigned DROP_CNT_W       = 16;

  // Replicates bit w-1 of v into every bit above it; w must be 1..WORD_SIZE.
  function automatic logic [WORD_SIZE-1:0] sext(input logic [WORD_SIZE-1:0] v,
                                                input int unsigned w);
    logic [WORD_SIZE-1:0] r;
    r = v;
    for (int unsigned i = 0; i < WORD_SIZE; i++) begin
      if (i >= w) r[i] = v[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/bb_dp_ram.sv
// Simple dual-port sample RAM: one synchronous write port, one registered read port.
module bb_dp_ram #(
  parameter int unsigned W  = 24,
  parameter int unsigned N  = 256,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/i2s_block_buffer.sv
// Multi-channel ping-pong block buffer between i2s_rx and the DSP stage:
// interleaved sample capture, block handoff handshake, slip/overrun tracking, latency-1 reads.
module i2s_block_buffer import i2s_buf_pkg::*; #(
  parameter int unsigned SAMPLE_W = DEFAULT_SAMPLE_W,
  parameter int unsigned OUT_W    = DEFAULT_OUT_W,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int unsigned IDX_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [CH_W-1:0]       in_ch,
  input  logic [SAMPLE_W-1:0]   in_data,
  output logic                  blk_valid,
  output logic [BLK_SEQ_W-1:0]  blk_seq,
  input  logic                  blk_done,
  input  logic                  rd_en,
  input  logic [CH_W-1:0]       rd_ch,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [OUT_W-1:0]      rd_data,
  output logic                  rd_data_valid,
  output logic                  sync_err,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  input  logic                  clr_err
);

  localparam int unsigned RAM_N = 2 * NUM_CH * DEPTH;
  localparam int unsigned AW    = $clog2(RAM_N);
  localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH - 1);
  localparam logic [CH_W-1:0]  CH_AFTER_0 = (NUM_CH > 1) ? CH_W'(1) : '0;

  // Dense {bank, ch, idx} packing so non-power-of-two NUM_CH/DEPTH waste no RAM.
  function automatic logic [AW-1:0] ram_addr(input logic bank,
                                             input logic [CH_W-1:0] ch,
                                             input logic [IDX_W-1:0] idx);
    return AW'((32'(bank) * NUM_CH + 32'(ch)) * DEPTH + 32'(idx));
  endfunction

  logic              wbank;
  logic              started;
  logic [CH_W-1:0]   exp_ch;
  logic [IDX_W-1:0]  widx;
  logic              in_order, accept, slip, complete, handoff, overrun;
  logic              rd_ok, rd_in_range, oob_q;
  logic [SAMPLE_W-1:0]  ram_q;
  logic [WORD_SIZE-1:0] ext;

  assign in_order = in_valid && (in_ch == exp_ch);
  assign slip     = in_valid && !in_order;
  assign accept   = in_order || (slip && (in_ch == '0));
  assign complete = in_order && (exp_ch == LAST_CH) && (widx == LAST_IDX);
  assign handoff  = complete && (!blk_valid || blk_done);
  assign overrun  = complete && blk_valid && !blk_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_ch <= '0;
      widx   <= '0;
    end else if (in_order) begin
      if (exp_ch == LAST_CH) begin
        exp_ch <= '0;
        widx   <= (widx == LAST_IDX) ? '0 : widx + IDX_W'(1);
      end else begin
        exp_ch <= exp_ch + CH_W'(1);
      end
    end else if (slip) begin
      exp_ch <= (in_ch == '0) ? CH_AFTER_0 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank     <= 1'b0;
      blk_valid <= 1'b0;
      blk_seq   <= '0;
      started   <= 1'b0;
    end else if (handoff) begin
      wbank     <= ~wbank;
      blk_valid <= 1'b1;
      started   <= 1'b1;
      if (started) blk_seq <= blk_seq + BLK_SEQ_W'(1);
    end else if (blk_done) begin
      blk_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_err) begin
      sync_err <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (slip) sync_err <= 1'b1;
      if (overrun) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

  assign rd_ok       = rd_en && blk_valid;
  assign rd_in_range = (32'(rd_ch) < NUM_CH) && (32'(rd_idx) < DEPTH);

  // oob_q resets high so rd_data reads zero without resetting the RAM output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_valid <= 1'b0;
      oob_q         <= 1'b1;
    end else begin
      rd_data_valid <= rd_ok;
      if (rd_ok) oob_q <= !rd_in_range;
    end
  end

  bb_dp_ram #(
    .W  (SAMPLE_W),
    .N  (RAM_N),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (ram_addr(wbank, in_ch, widx)),
    .wdata (in_data),
    .re    (rd_ok && rd_in_range),
    .raddr (ram_addr(~wbank, rd_ch, rd_idx)),
    .rdata (ram_q)
  );

  assign ext     = sext(WORD_SIZE'(ram_q), SAMPLE_W);
  assign rd_data = oob_q ? '0 : OUT_W'($signed(ext));

endmodule

// File: tb/tb_i2s_block_buffer.sv
// Randomized scoreboard bench for i2s_block_buffer against a block-level reference model.
module tb_i2s_block_buffer;

  localparam int NCH = 3;
  localparam int DEP = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_ch = '0;
  logic [23:0] in_data = '0;
  logic        blk_valid;
  logic [7:0]  blk_seq;
  logic        blk_done = 1'b0;
  logic        rd_en = 1'b0;
  logic [1:0]  rd_ch = '0;
  logic [2:0]  rd_idx = '0;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic        sync_err;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        clr_err = 1'b0;

  i2s_block_buffer #(
    .SAMPLE_W (24),
    .OUT_W    (32),
    .NUM_CH   (NCH),
    .DEPTH    (DEP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ch         (in_ch),
    .in_data       (in_data),
    .blk_valid     (blk_valid),
    .blk_seq       (blk_seq),
    .blk_done      (blk_done),
    .rd_en         (rd_en),
    .rd_ch         (rd_ch),
    .rd_idx        (rd_idx),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .sync_err      (sync_err),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt),
    .clr_err       (clr_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int unsigned stamp;
    logic        rdv;
    logic [31:0] rdd;
    logic        bv;
    logic [7:0]  seq;
    logic        serr;
    logic        ovf;
    logic [15:0] drop;
  } exp_t;

  exp_t sb[$];

  // Reference model: the block being assembled and the block the reader owns.
  logic [23:0] asm_blk [NCH][DEP];
  logic [23:0] own_blk [NCH][DEP];
  int          m_exp, m_widx, m_seq, m_drop;
  bit          m_bv, m_started, m_serr, m_ovf;
  logic [31:0] m_rdd;

  task automatic model_reset();
    m_exp = 0; m_widx = 0; m_seq = 0; m_drop = 0;
    m_bv = 0; m_started = 0; m_serr = 0; m_ovf = 0;
    m_rdd = '0;
  endtask

  task automatic model_step();
    exp_t e;
    bit complete, handoff, slipped;
    logic [23:0] s;
    e.stamp = cyc;
    if (rd_en && m_bv) begin
      if (int'(rd_ch) < NCH && int'(rd_idx) < DEP) begin
        s = own_blk[rd_ch][rd_idx];
        m_rdd = {{8{s[23]}}, s};
      end else begin
        m_rdd = '0;
      end
      e.rdv = 1'b1;
    end else begin
      e.rdv = 1'b0;
    end
    e.rdd = m_rdd;

    complete = 0;
    slipped  = 0;
    if (in_valid) begin
      if (int'(in_ch) == m_exp) begin
        asm_blk[in_ch][m_widx] = in_data;
        if (m_exp == NCH - 1) begin
          m_exp = 0;
          if (m_widx == DEP - 1) begin
            complete = 1;
            m_widx = 0;
          end else begin
            m_widx++;
          end
        end else begin
          m_exp++;
        end
      end else begin
        slipped = 1;
        if (in_ch == 2'd0) begin
          asm_blk[0][m_widx] = in_data;
          m_exp = (NCH == 1) ? 0 : 1;
        end else begin
          m_exp = 0;
        end
      end
    end

    handoff = complete && (!m_bv || blk_done);
    if (handoff) begin
      own_blk = asm_blk;
      if (m_started) m_seq = (m_seq + 1) % 256;
      m_started = 1;
      m_bv = 1;
    end else if (blk_done) begin
      m_bv = 0;
    end

    if (clr_err) begin
      m_serr = 0; m_ovf = 0; m_drop = 0;
    end else begin
      if (slipped) m_serr = 1;
      if (complete && !handoff) begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end
    end

    e.bv   = m_bv;
    e.seq  = 8'(m_seq);
    e.serr = m_serr;
    e.ovf  = m_ovf;
    e.drop = 16'(m_drop);
    sb.push_back(e);
  endtask

  task automatic drive_idle();
    in_valid = 0; in_ch = '0; in_data = '0; blk_done = 0;
    rd_en = 0; rd_ch = '0; rd_idx = '0; clr_err = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_blk_valid"}, 32'(blk_valid), 32'd0);
    chk({tag, "_blk_seq"}, 32'(blk_seq), 32'd0);
    chk({tag, "_rd_data"}, rd_data, 32'd0);
    chk({tag, "_rd_data_valid"}, 32'(rd_data_valid), 32'd0);
    chk({tag, "_sync_err"}, 32'(sync_err), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
  endtask

  // Reset is pulled between edges, so the outputs must clear without a clock.
  task automatic do_reset();
    drive_idle();
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs("midreset");
    sb.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic drive_random(input int n);
    int done_pct;
    bit will_complete;
    in_valid = ($urandom_range(0, 9) < 7);
    in_ch = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'(m_exp);
    case ($urandom_range(0, 7))
      0:       in_data = 24'h800000;
      1:       in_data = 24'h7FFFFF;
      default: in_data = 24'($urandom);
    endcase
    done_pct = (n >= 800 && n < 1600) ? 3 : 35;
    will_complete = in_valid && int'(in_ch) == m_exp && m_exp == NCH - 1 && m_widx == DEP - 1;
    if (m_bv) blk_done = (will_complete && $urandom_range(0, 1) == 1) ||
                         ($urandom_range(0, 99) < done_pct);
    else      blk_done = ($urandom_range(0, 19) == 0);
    rd_en   = ($urandom_range(0, 1) == 1);
    rd_ch   = 2'($urandom_range(0, 3));
    rd_idx  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    clr_err = ($urandom_range(0, 49) == 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (sb.size() > 0 && sb[0].stamp < cyc) begin
          e = sb.pop_front();
          chk("rd_data_valid", 32'(rd_data_valid), 32'(e.rdv));
          chk("rd_data", rd_data, e.rdd);
          chk("blk_valid", 32'(blk_valid), 32'(e.bv));
          chk("blk_seq", 32'(blk_seq), 32'(e.seq));
          chk("sync_err", 32'(sync_err), 32'(e.serr));
          chk("overflow", 32'(overflow), 32'(e.ovf));
          chk("drop_cnt", 32'(drop_cnt), 32'(e.drop));
        end
      end
    end
  end

  initial begin : driver
    bit did_mid_reset;
    did_mid_reset = 0;
    drive_idle();
    model_reset();
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      #1;
      if (!did_mid_reset && n >= 2000 && m_bv && m_widx != 0) begin
        did_mid_reset = 1;
        do_reset();
      end else begin
        drive_random(n);
        model_step();
      end
    end
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      drive_idle();
      model_step();
    end
    @(negedge clk);
    @(negedge clk);
    chk("mid_block_reset_exercised", 32'(did_mid_reset), 32'd1);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_block_buffer.md
Name: i2s_block_buffer

Overview:
Parametrised multi-channel ping-pong block buffer between i2s_rx and the DSP processing stage, all in the system clock domain. Interleaved per-channel samples are written into one bank. When a block of DEPTH frames is complete, the bank is handed to the reader with a valid/done handshake while writing continues in the other bank. It detects channel-order slips and reader overruns, and provides sign-extended, registered random-access reads.

Parameters:
SAMPLE_W, 24, width of incoming signed samples
OUT_W, 32, width of rd_data; must be >= SAMPLE_W; samples are sign-extended to it
NUM_CH, 2, channels per frame; must be >= 1
DEPTH, 64, frames per block; must be >= 2; need not be a power of two
CH_W, $clog2(NUM_CH) (min 1), channel index width
IDX_W, $clog2(DEPTH), frame index width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  sample strobe, one cycle per sample
in_ch  in  CH_W  channel of in_data
in_data  in  SAMPLE_W  signed sample
blk_valid  out  1  a completed block is owned by the reader
blk_seq  out  8  block sequence number, wraps 255->0
blk_done  in  1  reader releases its block (pulse)
rd_en  in  1  read request
rd_ch  in  CH_W  read channel
rd_idx  in  IDX_W  read frame index
rd_data  out  OUT_W  sign-extended sample
rd_data_valid  out  1  rd_data is valid
sync_err  out  1  sticky: channel-order slip seen
overflow  out  1  sticky: a block was discarded
drop_cnt  out  16  discarded-block count, saturates at 16'hFFFF
clr_err  in  1  clears sync_err, overflow and drop_cnt

Behaviour:
- Reset (async, rst_n=0): blk_valid=0, blk_seq=0, rd_data=0, rd_data_valid=0, sync_err=0, overflow=0, drop_cnt=0. Internally wbank=0, exp_ch=0, widx=0. RAM contents are not cleared.
- Reset asserted mid-block discards both banks' ownership. The reader must re-wait for blk_valid.
- Write acceptance: when in_valid=1 and in_ch==exp_ch, the sample is written to mem[wbank][in_ch][widx].
  - exp_ch then increments.
  - After channel NUM_CH-1, exp_ch returns to 0 and widx increments.
- Channel slip: when in_valid=1 and in_ch!=exp_ch:
  - sync_err is set.
  - If in_ch==0, the sample is accepted as a new frame start: written at the current widx, exp_ch becomes 1 (or 0 if NUM_CH=1), and widx is unchanged. The partial frame is overwritten.
  - Otherwise the sample is dropped and exp_ch becomes 0.
- Block completion: an accepted write with widx==DEPTH-1 and in_ch==NUM_CH-1.
  - If blk_valid==0, or blk_done=1 in the same cycle: next cycle wbank toggles, widx=0, blk_valid=1, blk_seq increments (skipped on the very first block after reset, so the first block reads blk_seq=0).
  - Otherwise (overrun): wbank is unchanged and widx=0, so the block is overwritten. overflow is set, drop_cnt increments (saturating), and blk_valid/blk_seq are unchanged.
- Handshake:
  - blk_done with blk_valid=1 clears blk_valid the next cycle.
  - blk_done with blk_valid=0 is ignored.
  - The read bank is always ~wbank.
- Reads, latency 1:
  - rd_en=1 with blk_valid=1: the next cycle gives rd_data_valid=1 and rd_data = sign-extended mem[~wbank][rd_ch][rd_idx].
  - rd_idx>=DEPTH or rd_ch>=NUM_CH gives rd_data=0 with rd_data_valid=1.
  - rd_en with blk_valid=0 gives rd_data_valid=0 and rd_data holds its value.
  - rd_data_valid is 0 in any cycle without a qualifying rd_en.
  - A read in the same cycle as a handoff uses the pre-handoff bank.
- clr_err has priority over setting in the same cycle: the flags clear and drop_cnt=0.
- Writes to the write bank never alter the bank owned by the reader.

Decomposition:
- Package i2s_buf_pkg holds:
  - default widths (SAMPLE_W=24, OUT_W=32, WORD_SIZE=32);
  - the BLK_SEQ_W=8 and DROP_CNT_W=16 constants;
  - a sign-extension function.
- One sub-module, bb_dp_ram: simple dual-port RAM with one synchronous write port and one registered read port, depth 2*NUM_CH*DEPTH, address {bank, ch, idx}.
- Top-level holds the write FSM (exp_ch/widx), the bank-ownership logic and the error counters.

Test Plan:
1. NUM_CH=2, DEPTH=4: write 8 samples ch0/ch1 alternating, values 0x000001..0x000008 -> blk_valid=1 the cycle after the 8th; blk_seq=0; rd (ch1, idx3) returns 0x00000008 one cycle later with rd_data_valid=1.
2. Sign extension: in_data=24'h800000 -> rd_data=32'hFF800000; in_data=24'h7FFFFF -> 32'h007FFFFF.
3. Overrun: complete block A, never assert blk_done, complete block B -> overflow=1, drop_cnt=1, blk_valid stays 1; reads still return block A; blk_done then block C -> blk_seq=1, contents are C.
4. Channel slip: ch0, ch0 -> sync_err=1, second sample written at the same widx. Then ch0, ch1, ch1 -> third dropped, exp_ch=0. clr_err -> sync_err=0.
5. Simultaneous blk_done and block completion in one cycle -> handoff occurs, overflow stays 0, blk_valid stays 1, blk_seq increments.
6. rst_n pulsed low mid-block with blk_valid=1 -> all outputs zero immediately (asynchronously), without waiting for a clock edge. The next full block yields blk_seq=0.
